// File: rtl/fifo_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_serial_tx
// Description : Read-side drain engine for a synchronous byte FIFO. Pops one
//               word per frame through the FIFO read port (registered read
//               data, valid the cycle after r_en) and shifts it out as a
//               serial frame: one start bit (0), DATA_W data bits LSB-first,
//               STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT clocks.
//
// Parameters  : DATA_W        width of the FIFO word / serial data field
//               CLKS_PER_BIT  clocks per bit period, 1..65535
//               STOP_BITS     number of stop bit periods, 1 or 2
//
// Ports       : clk         system clock, rising edge
//               rst         synchronous active-high reset
//               fifo_empty  FIFO empty flag, only looked at in IDLE
//               rd_data     FIFO read data, valid the cycle after r_en
//               r_en        FIFO pop strobe, one cycle per frame
//               tx          serial line, idle high, registered
//               busy        high whenever the engine is not in IDLE
//               tx_done     pulse in the last cycle of the final stop bit
//
// Revision    : 1.0  initial release
// ============================================================================
module fifo_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] rd_data,
    output logic              r_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Divide counter runs 0..CLKS_PER_BIT-1; keep at least one bit so the
    // CLKS_PER_BIT=1 case still has a legal (constant zero) counter.
    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    // Bit index runs 0..DATA_W-1 in DATA and 0..STOP_BITS-1 in STOP; the
    // stop range (at most 0..1) always fits inside the data range width.
    localparam int c_BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(DATA_W - 1);
    localparam logic [c_BIT_W-1:0] c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE   = c_BIT_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LATCH = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_BIT_W-1:0]  r_bit_idx;
    logic [DATA_W-1:0]   r_shift;
    logic                r_tx;

    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [c_BIT_W-1:0]  w_bit_nxt;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic                w_tx_nxt;
    logic                w_bit_end;

    // Last clock of the current bit period.
    assign w_bit_end = (r_cnt == c_CNT_MAX);

    // ------------------------------------------------------------------------
    // Next-state, counter and shift-register logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                if (!fifo_empty) begin
                    w_state_nxt = S_POP;
                end
            end

            // r_en is decoded from this state; the FIFO returns the word in
            // the following (LATCH) cycle.
            S_POP: begin
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
                w_state_nxt = S_LATCH;
            end

            S_LATCH: begin
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
                w_shift_nxt = rd_data;
                w_state_nxt = S_START;
            end

            S_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_idx == c_BIT_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + c_BIT_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            // The bit index is reused to count stop-bit periods.
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit_idx == c_STOP_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bit_nxt = r_bit_idx + c_BIT_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Line value for the next cycle. tx is a register, so it is computed from
    // the state being entered: the first START cycle already shows 0, and
    // each data bit appears in the same cycle the shift register presents it.
    // ------------------------------------------------------------------------
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all decoded from registers only, so they are glitch-free.
    // ------------------------------------------------------------------------
    assign tx      = r_tx;
    assign r_en    = (r_state == S_POP);
    assign busy    = (r_state != S_IDLE);
    assign tx_done = (r_state == S_STOP) && w_bit_end && (r_bit_idx == c_STOP_LAST);

endmodule
`default_nettype wire

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
Read-side drain engine for the team's synchronous byte FIFO. It pops one byte at a time through the FIFO's read port (r_en, with registered read data that arrives one cycle later). It then shifts each byte out as an asynchronous-style serial frame: start bit, DATA_W data bits LSB-first, STOP_BITS stop bits. It sits between a FIFO and an off-chip or inter-block serial line, and it is the reader/transmitter counterpart to the FIFO's writer.

Parameters:
DATA_W, 8, width of FIFO word and of the serial data field.
CLKS_PER_BIT, 4, clk cycles per serial bit period; legal range 1..65535.
STOP_BITS, 1, number of stop bit periods; legal values 1 or 2.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
fifo_empty  in  1  high when the FIFO holds no data; sampled only in IDLE.
rd_data  in  DATA_W  FIFO read data, valid the cycle after r_en is high.
r_en  out  1  FIFO pop strobe, exactly one cycle per frame.
tx  out  1  serial line, idle high, registered.
busy  out  1  high in every state except IDLE.
tx_done  out  1  one-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE, tx=1, r_en=0, busy=0, tx_done=0.
  - Shift register, bit counter and clock-divide counter are 0.
- States: IDLE, POP, LATCH, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If fifo_empty=0, go to POP next cycle; otherwise stay in IDLE.
- POP:
  - Lasts 1 cycle; r_en=1 only in this state (decoded from the registered state, glitch-free).
  - Next state is LATCH unconditionally; fifo_empty is ignored here.
- LATCH:
  - Lasts 1 cycle; rd_data is captured into the shift register at the end of this cycle.
  - Next state is START.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - Then go to DATA with bit index 0.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment the bit index.
  - After bit DATA_W-1 completes, go to STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done=1 in the final cycle of STOP, then go to IDLE.
- tx line timing:
  - tx is registered; its value during each state cycle is as listed above.
  - The first cycle of START shows tx=0.
- Latency:
  - fifo_empty falls in cycle n (observed in IDLE) → r_en high in cycle n+1 → tx falls in cycle n+3.
  - Frame length = (1+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back frames:
  - After STOP, IDLE, POP and LATCH each take one cycle.
  - So consecutive frames are separated by exactly 3 extra tx=1 cycles beyond the stop bits.
- Counters:
  - The divide counter counts 0..CLKS_PER_BIT-1; it is sized as clog2(CLKS_PER_BIT) or 1 bit, whichever is larger.
  - The counter wraps to 0 on each bit boundary.
  - The bit index runs 0..DATA_W-1 and never exceeds it.
- CLKS_PER_BIT=1: every bit lasts exactly one cycle; there are no skipped or duplicated bits.
- fifo_empty changes outside IDLE have no effect. No pop is issued while busy.
- Reset mid-frame:
  - On the next edge, tx=1, state=IDLE, and no tx_done is issued.
  - A byte already popped is discarded (data loss on reset is accepted).
- rst has priority over every state transition.

Test Plan:
- Reset, fifo_empty=1 held 50 cycles → tx=1, r_en=0, busy=0 throughout.
- CLKS_PER_BIT=4, STOP_BITS=1, one byte 0xA5:
  - fifo_empty falls at cycle 0 → r_en=1 only at cycle 1.
  - tx=0 cycles 3–6, then bits 1,0,1,0,0,1,0,1 at 4 cycles each (cycles 7–38).
  - tx=1 cycles 39–42, tx_done=1 at cycle 42, busy low from cycle 43.
- Two queued bytes 0x00 then 0xFF, fifo_empty held low:
  - Exactly two r_en pulses, 43 cycles apart.
  - Line reads start, eight 0s, stop, 3 idle-high cycles, start, eight 1s, stop.
- CLKS_PER_BIT=1, STOP_BITS=2, byte 0x3C → frame of 11 cycles: 0, 0,0,1,1,1,1,0,0, 1,1; tx_done on the 11th.
- rst asserted during DATA bit 3 of 0x5A → tx=1, busy=0 on the next cycle; no tx_done; after release with fifo_empty=1 the line stays idle.
- fifo_empty toggled every cycle during a frame → no extra r_en pulses; the frame content is unchanged.
